// File: rtl/instr_fetch.sv
// -----------------------------------------------------------------------------
// instr_fetch
//   Instruction fetch stage downstream of the program counter. On request it
//   latches pc and reads two consecutive bytes from a byte-wide synchronous
//   memory (1-cycle read latency). It assembles them into a 16-bit instruction
//   {byte[pc], byte[pc+1]}, then pulses instr_valid and pc_en together so the
//   PC only advances once the fetch has landed.
//
// Ports
//   clk          system clock, rising edge
//   rst_n        synchronous active-low reset
//   fetch_req    fetch request, only looked at in IDLE
//   pc           byte address of the instruction's high byte
//   mem_rd_en    memory read strobe
//   mem_addr     memory byte address
//   mem_rdata    memory read data, valid the cycle after mem_rd_en
//   instr        assembled instruction
//   instr_valid  one-cycle pulse, instr holds the new instruction
//   pc_en        one-cycle pulse coincident with instr_valid (PC enable)
//   busy         high in every state except IDLE
// -----------------------------------------------------------------------------
module instr_fetch #(
    parameter int ADDR_W = 3,
    parameter int DATA_W = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                fetch_req,
    input  logic [ADDR_W-1:0]   pc,
    output logic                mem_rd_en,
    output logic [ADDR_W-1:0]   mem_addr,
    input  logic [DATA_W-1:0]   mem_rdata,
    output logic [2*DATA_W-1:0] instr,
    output logic                instr_valid,
    output logic                pc_en,
    output logic                busy
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        RD_HI  = 3'd1,
        RD_LO  = 3'd2,
        CAP_LO = 3'd3,
        DONE   = 3'd4
    } state_t;

    state_t              state, state_n;
    logic [ADDR_W-1:0]   pc_q;
    logic [DATA_W-1:0]   hi_q;

    // State and datapath registers. instr is only written in CAP_LO, so the
    // previous instruction stays visible for the whole of the next fetch.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            pc_q  <= '0;
            hi_q  <= '0;
            instr <= '0;
        end else begin
            state <= state_n;
            if (state == IDLE && fetch_req)
                pc_q <= pc;
            // The high byte read issued in RD_HI arrives while in RD_LO.
            if (state == RD_LO)
                hi_q <= mem_rdata;
            // The low byte read issued in RD_LO arrives while in CAP_LO.
            if (state == CAP_LO)
                instr <= {hi_q, mem_rdata};
        end
    end

    // Next-state and output decode, purely from the state register.
    always_comb begin
        state_n     = state;
        mem_rd_en   = 1'b0;
        mem_addr    = '0;
        instr_valid = 1'b0;
        pc_en       = 1'b0;
        busy        = 1'b1;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (fetch_req)
                    state_n = RD_HI;
            end
            RD_HI: begin
                mem_rd_en = 1'b1;
                mem_addr  = pc_q;
                state_n   = RD_LO;
            end
            RD_LO: begin
                mem_rd_en = 1'b1;
                // Wraps modulo 2^ADDR_W: the last byte pairs with byte 0.
                mem_addr  = pc_q + ADDR_W'(1);
                state_n   = CAP_LO;
            end
            CAP_LO: begin
                state_n = DONE;
            end
            DONE: begin
                instr_valid = 1'b1;
                pc_en       = 1'b1;
                state_n     = IDLE;
            end
            default: begin
                busy    = 1'b0;
                state_n = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_instr_fetch.sv
// -----------------------------------------------------------------------------
// tb_instr_fetch
//   Self-checking bench for instr_fetch. A byte-array memory with 1-cycle
//   read latency answers the DUT. When no read is issued, it drives junk on
//   the data bus so that mistimed captures show up. Expected instructions
//   come from the rule {mem[pc], mem[(pc+1) mod 8]}. Latency is modelled as
//   4 cycles from request to valid, and throughput as 5 cycles per fetch.
//   Inputs are driven and outputs sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_instr_fetch;
    localparam int AW = 3;
    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          fetch_req = 1'b0;
    logic [AW-1:0] pc = '0;
    logic          mem_rd_en;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_rdata;
    logic [2*DW-1:0] instr;
    logic          instr_valid, pc_en, busy;

    logic [DW-1:0]   mem [8];
    logic [2*DW-1:0] last_instr = '0;
    int vectors = 0;
    int errors  = 0;

    always #5 clk = ~clk;

    always @(posedge clk)
        mem_rdata <= mem_rd_en ? mem[mem_addr] : DW'($urandom);

    instr_fetch #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk(clk), .rst_n(rst_n), .fetch_req(fetch_req), .pc(pc),
        .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
        .instr(instr), .instr_valid(instr_valid), .pc_en(pc_en), .busy(busy)
    );

    function automatic logic [2*DW-1:0] model(input logic [AW-1:0] p);
        logic [AW-1:0] q;
        q = p + 3'd1;
        return {mem[p], mem[q]};
    endfunction

    task automatic fill_random();
        for (int i = 0; i < 8; i++) mem[i] = DW'($urandom);
    endtask

    task automatic test_reset();
        fill_random();
        rst_n = 1'b0; fetch_req = 1'b1; pc = '0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            vectors++;
            if (busy !== 1'b0 || instr_valid !== 1'b0 || pc_en !== 1'b0 ||
                mem_rd_en !== 1'b0 || instr !== 16'h0000) begin
                errors++;
                $display("FAIL reset_hold%0d: busy=%b valid=%b pc_en=%b rd_en=%b instr=%h, expected all 0",
                         i, busy, instr_valid, pc_en, mem_rd_en, instr);
            end
        end
        rst_n = 1'b1;
        @(negedge clk);
        fetch_req = 1'b0;
        vectors++;
        if (busy !== 1'b1 || mem_rd_en !== 1'b1 || mem_addr !== 3'd0) begin
            errors++;
            $display("FAIL reset_release: busy=%b rd_en=%b addr=%0d, expected 1 1 0",
                     busy, mem_rd_en, mem_addr);
        end
        repeat (3) @(negedge clk);
        vectors++;
        if (instr_valid !== 1'b1 || instr !== model(3'd0)) begin
            errors++;
            $display("FAIL reset_first_fetch: valid=%b instr=%h, expected 1 %h",
                     instr_valid, instr, model(3'd0));
        end
        last_instr = model(3'd0);
        @(negedge clk);
        vectors++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_first_idle: busy=%b, expected 0", busy);
        end
    endtask

    // One fetch from IDLE at address p; with mid set, pc is changed and a
    // stray request is pulsed during RD_LO, both of which must be ignored.
    task automatic do_fetch(input logic [AW-1:0] p, input bit mid, input string nm);
        logic [2*DW-1:0] exp;
        logic [AW-1:0]   p1;
        exp = model(p);
        p1  = p + 3'd1;
        pc = p; fetch_req = 1'b1;
        @(negedge clk);                                   // RD_HI
        fetch_req = 1'b0;
        vectors++;
        if (mem_rd_en !== 1'b1 || mem_addr !== p || busy !== 1'b1 || instr_valid !== 1'b0) begin
            errors++;
            $display("FAIL %s rd_hi: rd_en=%b addr=%0d busy=%b valid=%b, expected 1 %0d 1 0",
                     nm, mem_rd_en, mem_addr, busy, instr_valid, p);
        end
        @(negedge clk);                                   // RD_LO
        vectors++;
        if (mem_rd_en !== 1'b1 || mem_addr !== p1 || instr !== last_instr || pc_en !== 1'b0) begin
            errors++;
            $display("FAIL %s rd_lo: rd_en=%b addr=%0d instr=%h pc_en=%b, expected 1 %0d %h 0",
                     nm, mem_rd_en, mem_addr, instr, pc_en, p1, last_instr);
        end
        if (mid) begin
            pc = ~p; fetch_req = 1'b1;
        end
        @(negedge clk);                                   // CAP_LO
        fetch_req = 1'b0;
        vectors++;
        if (mem_rd_en !== 1'b0 || mem_addr !== 3'd0 || instr !== last_instr ||
            instr_valid !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL %s cap_lo: rd_en=%b addr=%0d instr=%h valid=%b busy=%b, expected 0 0 %h 0 1",
                     nm, mem_rd_en, mem_addr, instr, instr_valid, busy, last_instr);
        end
        @(negedge clk);                                   // DONE
        vectors++;
        if (instr_valid !== 1'b1 || pc_en !== 1'b1 || instr !== exp || busy !== 1'b1 || mem_rd_en !== 1'b0) begin
            errors++;
            $display("FAIL %s done: valid=%b pc_en=%b instr=%h busy=%b rd_en=%b, expected 1 1 %h 1 0",
                     nm, instr_valid, pc_en, instr, busy, mem_rd_en, exp);
        end
        last_instr = exp;
        @(negedge clk);                                   // IDLE
        vectors++;
        if (instr_valid !== 1'b0 || pc_en !== 1'b0 || busy !== 1'b0 || instr !== exp) begin
            errors++;
            $display("FAIL %s idle: valid=%b pc_en=%b busy=%b instr=%h, expected 0 0 0 %h",
                     nm, instr_valid, pc_en, busy, instr, exp);
        end
        @(negedge clk);                                   // must remain idle
        vectors++;
        if (busy !== 1'b0 || mem_rd_en !== 1'b0) begin
            errors++;
            $display("FAIL %s no_extra_fetch: busy=%b rd_en=%b, expected 0 0", nm, busy, mem_rd_en);
        end
    endtask

    task automatic test_single();
        fill_random();
        mem[0] = 8'hA1; mem[1] = 8'hB2;
        do_fetch(3'd0, 1'b0, "single");
        vectors++;
        if (last_instr !== 16'hA1B2 || instr !== 16'hA1B2) begin
            errors++;
            $display("FAIL single_value: instr=%h, expected a1b2", instr);
        end
    endtask

    task automatic test_wrap();
        fill_random();
        mem[7] = 8'hC3; mem[0] = 8'hD4;
        do_fetch(3'd7, 1'b0, "wrap");
        vectors++;
        if (instr !== 16'hC3D4) begin
            errors++;
            $display("FAIL wrap_value: instr=%h, expected c3d4", instr);
        end
    endtask

    task automatic test_mid_change();
        fill_random();
        do_fetch(3'd3, 1'b1, "mid_change");
    endtask

    task automatic test_random();
        for (int i = 0; i < 12; i++) begin
            fill_random();
            do_fetch(AW'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), "random");
        end
    endtask

    task automatic test_back_to_back();
        logic [2*DW-1:0] tab [5];
        logic [AW-1:0]   pcm;
        int n, gap;
        tab[0] = 16'h1122; tab[1] = 16'h3344; tab[2] = 16'h5566;
        tab[3] = 16'h7788; tab[4] = 16'h1122;
        for (int i = 0; i < 8; i++) mem[i] = DW'(8'h11 * (i + 1));
        pcm = '0; pc = pcm; fetch_req = 1'b1;
        n = 0; gap = 0;
        for (int c = 0; c < 40 && n < 5; c++) begin
            @(negedge clk);
            gap++;
            if (instr_valid) begin
                vectors++;
                if (instr !== tab[n] || gap !== ((n == 0) ? 4 : 5) || pc_en !== 1'b1) begin
                    errors++;
                    $display("FAIL b2b%0d: instr=%h gap=%0d pc_en=%b, expected %h %0d 1",
                             n, instr, gap, pc_en, tab[n], (n == 0) ? 4 : 5);
                end
                last_instr = tab[n];
                pcm = pcm + 3'd2;     // PC advances on pc_en, before the next accept
                pc  = pcm;
                n++;
                gap = 0;
            end
        end
        fetch_req = 1'b0;
        vectors++;
        if (n !== 5) begin
            errors++;
            $display("FAIL b2b_timeout: got %0d instructions, expected 5", n);
        end
        @(negedge clk);
        vectors++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL b2b_idle: busy=%b, expected 0", busy);
        end
    endtask

    task automatic test_reset_mid();
        fill_random();
        mem[5] = 8'h5A; mem[6] = 8'hA5;
        pc = 3'd5; fetch_req = 1'b1;
        @(negedge clk);                                   // RD_HI
        fetch_req = 1'b0;
        @(negedge clk);                                   // RD_LO
        @(negedge clk);                                   // CAP_LO
        rst_n = 1'b0;
        @(negedge clk);
        vectors++;
        if (instr !== 16'h0000 || busy !== 1'b0 || instr_valid !== 1'b0 ||
            pc_en !== 1'b0 || mem_rd_en !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid: instr=%h busy=%b valid=%b pc_en=%b rd_en=%b, expected 0 0 0 0 0",
                     instr, busy, instr_valid, pc_en, mem_rd_en);
        end
        last_instr = '0;
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            vectors++;
            if (instr_valid !== 1'b0 || pc_en !== 1'b0 || busy !== 1'b0 || instr !== 16'h0000) begin
                errors++;
                $display("FAIL reset_mid_after%0d: valid=%b pc_en=%b busy=%b instr=%h, expected 0 0 0 0000",
                         i, instr_valid, pc_en, busy, instr);
            end
        end
        do_fetch(3'd5, 1'b0, "after_reset");
    endtask

    initial begin
        test_reset();
        test_single();
        test_wrap();
        test_mid_change();
        test_back_to_back();
        test_random();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
